// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO reader.
// State encoding and default word/counter widths.
package fifo_pkg;
  localparam int FIFO_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;
endpackage

// File: rtl/fifo_reader_skid.sv
// Two-entry in-order output buffer.
// Slot 0 is always the oldest word.
module fifo_reader_skid
  import fifo_pkg::*;
#(
  parameter int W = FIFO_W
) (
  input  logic         clk,
  input  logic         rstN,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_slot0;
  logic [W-1:0] r_slot1;
  logic [1:0]   r_occ;

  // Shift/fill slots on push and pop; a simultaneous push+pop keeps occupancy.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_occ   <= 2'd0;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          if (r_occ == 2'd0) r_slot0 <= i_data;
          else               r_slot1 <= i_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_occ   <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_slot0 <= r_slot1;
            r_slot1 <= i_data;
          end else begin
            r_slot0 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_data = r_slot0;
  assign o_occ  = r_occ;

endmodule

// File: rtl/fifo_reader.sv
// Reads a 1-cycle-latency FIFO and presents
// words on a valid/ready stream with a counter.
module fifo_reader
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_W,
  parameter int CNT_WIDTH  = CNT_W
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  busy
);

  state_e                 r_state;
  state_e                 w_next;
  logic                   r_in_flight;
  logic [CNT_WIDTH-1:0]   r_rd_count;
  logic [1:0]             w_occ;
  logic                   w_pop;
  logic [2:0]             w_load;
  logic                   w_room;
  logic                   w_empty_all;

  assign m_valid = (w_occ != 2'd0);
  assign w_pop   = m_valid & m_ready;

  // A word leaving on this edge frees its slot for a read issued now,
  // which keeps one word per cycle in steady state.
  assign w_load = {1'b0, w_occ} + {2'b00, r_in_flight}
                - {2'b00, w_pop};
  assign w_room = (w_load < 3'd2);

  assign fifo_rd_en = enable & ~fifo_empty & w_room
                    & (r_state == RUN);

  assign w_empty_all = ~r_in_flight & (w_occ == 2'd0);
  assign busy        = (r_state != IDLE);
  assign rd_count    = r_rd_count;

  // Track the outstanding read and count completed handshakes.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_state     <= IDLE;
      r_in_flight <= 1'b0;
      r_rd_count  <= '0;
    end else begin
      r_state     <= w_next;
      r_in_flight <= fifo_rd_en;
      if (w_pop) r_rd_count <= r_rd_count + 1'b1;
    end
  end

  // Next-state logic: reads only in RUN, DRAIN empties what is left.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (enable) w_next = RUN;
      end
      RUN: begin
        if (!enable) w_next = w_empty_all ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (enable)           w_next = RUN;
        else if (w_empty_all) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  fifo_reader_skid #(
    .W(FIFO_WIDTH)
  ) u_skid (
    .clk    (clk),
    .rstN   (rstN),
    .i_push (r_in_flight),
    .i_pop  (w_pop),
    .i_data (fifo_data),
    .o_data (m_data),
    .o_occ  (w_occ)
  );

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader with a
// 1-cycle-latency FIFO model and scoreboard.
module tb_fifo_reader;

  logic        clk;
  logic        rstN;
  logic        enable;
  logic        fifo_empty;
  logic [7:0]  fifo_data;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready;
  logic [7:0]  m_data;
  logic [15:0] rd_count;
  logic        busy;

  fifo_reader #(
    .FIFO_WIDTH(8),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rstN       (rstN),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .rd_count   (rd_count),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       rd_en;
    logic       valid;
    logic [7:0] data;
    logic       busy;
  } vec_t;

  vec_t        tbl [10];
  logic [7:0]  q [$];
  logic [7:0]  exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          n_acc = 0;
  int          n_hs = 0;
  int          hs0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    q.push_back(b);
    exp_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // One clock: sample handshakes before the edge, update FIFO after it.
  task automatic step();
    logic       acc;
    logic       hs;
    logic [7:0] d;
    #1;
    acc = fifo_rd_en && !fifo_empty;
    hs  = m_valid && m_ready;
    d   = m_data;
    if (hs) begin
      n_hs++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_word: got %0h want none", d);
      end else begin
        chk("word_order", {24'h0, d}, {24'h0, exp_q.pop_front()});
      end
    end
    @(posedge clk);
    #1;
    if (acc) begin
      n_acc++;
      fifo_data = q.pop_front();
    end else begin
      fifo_data = 8'hEE;
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic flush();
    enable  = 1'b1;
    m_ready = 1'b1;
    repeat (20) step();
    enable = 1'b0;
    for (int i = 0; i < 10; i++) if (busy) step();
    chk("flush_idle", {31'h0, busy}, 32'h0);
    chk("flush_all_out", exp_q.size(), 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h02, 1'b1};
    tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h04, 1'b1};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h05, 1'b1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

    rstN       = 1'b0;
    enable     = 1'b0;
    m_ready    = 1'b0;
    fifo_empty = 1'b1;
    fifo_data  = 8'h00;
    #12;
    chk("rst_valid", {31'h0, m_valid}, 32'h0);
    chk("rst_data", {24'h0, m_data}, 32'h0);
    chk("rst_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_count", {16'h0, rd_count}, 32'h0);

    for (int i = 1; i <= 5; i++) push(8'(i));
    @(negedge clk);
    rstN = 1'b1;
    @(posedge clk);
    #1;

    // Streaming
    for (int i = 0; i < 10; i++) begin
      enable  = tbl[i].en;
      m_ready = tbl[i].rdy;
      #1;
      chk($sformatf("s%0d_rd_en", i),
          {31'h0, fifo_rd_en}, {31'h0, tbl[i].rd_en});
      chk($sformatf("s%0d_valid", i),
          {31'h0, m_valid}, {31'h0, tbl[i].valid});
      if (tbl[i].valid)
        chk($sformatf("s%0d_data", i),
            {24'h0, m_data}, {24'h0, tbl[i].data});
      chk($sformatf("s%0d_busy", i),
          {31'h0, busy}, {31'h0, tbl[i].busy});
      step();
    end
    chk("stream_count", {16'h0, rd_count}, 32'd5);

    // Backpressure
    push(8'hA1); push(8'hA2); push(8'hA3); push(8'hA4);
    enable  = 1'b1;
    m_ready = 1'b0;
    n_acc   = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 3) begin
        chk("bp_valid_held", {31'h0, m_valid}, 32'h1);
        chk("bp_data_held", {24'h0, m_data}, 32'hA1);
      end
    end
    chk("bp_reads", n_acc, 32'd2);
    flush();
    chk("bp_count", {16'h0, rd_count}, 32'd9);

    // Drain
    push(8'hB1); push(8'hB2);
    enable  = 1'b1;
    m_ready = 1'b1;
    step();
    #1;
    chk("dr_issue", {31'h0, fifo_rd_en}, 32'h1);
    step();
    enable = 1'b0;
    n_acc  = 0;
    #1;
    chk("dr_busy0", {31'h0, busy}, 32'h1);
    chk("dr_no_rd", {31'h0, fifo_rd_en}, 32'h0);
    step();
    chk("dr_busy1", {31'h0, busy}, 32'h1);
    chk("dr_valid", {31'h0, m_valid}, 32'h1);
    chk("dr_data", {24'h0, m_data}, 32'hB1);
    step();
    chk("dr_busy2", {31'h0, busy}, 32'h1);
    chk("dr_empty", {31'h0, m_valid}, 32'h0);
    step();
    chk("dr_idle", {31'h0, busy}, 32'h0);
    chk("dr_reads", n_acc, 32'd0);
    flush();
    chk("dr_count", {16'h0, rd_count}, 32'd11);

    // Empty boundary
    push(8'hA5);
    enable  = 1'b1;
    m_ready = 1'b1;
    n_acc   = 0;
    hs0     = n_hs;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (fifo_empty)
        chk("em_no_rd", {31'h0, fifo_rd_en}, 32'h0);
      step();
    end
    chk("em_reads", n_acc, 32'd1);
    chk("em_words", n_hs - hs0, 32'd1);
    enable = 1'b0;
    step();
    step();
    chk("em_idle", {31'h0, busy}, 32'h0);

    // Counter wrap
    force dut.r_rd_count = 16'hFFFE;
    #1;
    release dut.r_rd_count;
    #1;
    chk("wr_forced", {16'h0, rd_count}, 32'hFFFE);
    push(8'h11); push(8'h22); push(8'h44);
    flush();
    chk("wr_count", {16'h0, rd_count}, 32'h0001);

    // Reset with words buffered and a read in flight
    push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
    enable  = 1'b1;
    m_ready = 1'b0;
    step(); step(); step();
    #1;
    chk("rs_pre_valid", {31'h0, m_valid}, 32'h1);
    #2;
    rstN = 1'b0;
    #1;
    chk("rs_valid", {31'h0, m_valid}, 32'h0);
    chk("rs_count", {16'h0, rd_count}, 32'h0);
    chk("rs_busy", {31'h0, busy}, 32'h0);
    chk("rs_rd_en", {31'h0, fifo_rd_en}, 32'h0);
    q.delete();
    exp_q.delete();
    fifo_empty = 1'b1;
    fifo_data  = 8'hEE;
    step();
    @(negedge clk);
    rstN = 1'b1;
    hs0  = n_hs;
    push(8'h33);
    flush();
    chk("rs_words", n_hs - hs0, 32'd1);
    chk("rs_count2", {16'h0, rd_count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
